// File: rtl/six_deng.sv
// Two-direction six-lamp traffic light: fixed S0..S3 cycle, one step per tick,
// with per-lamp registered countdowns of remaining on-time.
module six_deng #(
  parameter int GREEN_T  = 25,
  parameter int YELLOW_T = 5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] cnt_out,
  output logic [4:0] count_WERed,
  output logic [4:0] count_SNRed,
  output logic [4:0] count_WEgreen,
  output logic [4:0] count_SNgreen,
  output logic [4:0] count_WEyellow,
  output logic [4:0] count_SNyellow,
  output logic       WERed,
  output logic       SNRed,
  output logic       WEgreen,
  output logic       SNgreen,
  output logic       WEyellow,
  output logic       SNyellow
);
  localparam int         RED_T = GREEN_T + YELLOW_T;
  localparam logic [4:0] G5    = 5'(GREEN_T);
  localparam logic [4:0] Y5    = 5'(YELLOW_T);
  localparam logic [4:0] R5    = 5'(RED_T);

  // {WERed,WEyellow,WEgreen,SNRed,SNyellow,SNgreen}
  localparam logic [5:0] L_S0 = 6'b001100;
  localparam logic [5:0] L_S1 = 6'b010100;
  localparam logic [5:0] L_S2 = 6'b100001;
  localparam logic [5:0] L_S3 = 6'b100010;

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t     state, state_nx;
  logic [5:0] lamp_nx;
  logic [4:0] wr_nx, sr_nx, wg_nx, sg_nx, wy_nx, sy_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S0;
      cnt_out        <= L_S0;
      count_WERed    <= '0;
      count_SNRed    <= R5;
      count_WEgreen  <= G5;
      count_SNgreen  <= '0;
      count_WEyellow <= '0;
      count_SNyellow <= '0;
    end else begin
      state          <= state_nx;
      cnt_out        <= lamp_nx;
      count_WERed    <= wr_nx;
      count_SNRed    <= sr_nx;
      count_WEgreen  <= wg_nx;
      count_SNgreen  <= sg_nx;
      count_WEyellow <= wy_nx;
      count_SNyellow <= sy_nx;
    end
  end

  // The edge where the active green/yellow counter would hit 0 instead
  // enters the next phase; red keeps counting across both opposing phases.
  always_comb begin
    state_nx = state;
    lamp_nx  = cnt_out;
    wr_nx    = count_WERed;
    sr_nx    = count_SNRed;
    wg_nx    = count_WEgreen;
    sg_nx    = count_SNgreen;
    wy_nx    = count_WEyellow;
    sy_nx    = count_SNyellow;
    case (state)
      S0: begin
        wg_nx = count_WEgreen - 5'd1;
        sr_nx = count_SNRed - 5'd1;
        if (count_WEgreen == 5'd1) begin
          state_nx = S1;
          lamp_nx  = L_S1;
          wg_nx    = '0;
          wy_nx    = Y5;
        end
      end
      S1: begin
        wy_nx = count_WEyellow - 5'd1;
        sr_nx = count_SNRed - 5'd1;
        if (count_WEyellow == 5'd1) begin
          state_nx = S2;
          lamp_nx  = L_S2;
          wy_nx    = '0;
          sr_nx    = '0;
          wr_nx    = R5;
          sg_nx    = G5;
        end
      end
      S2: begin
        sg_nx = count_SNgreen - 5'd1;
        wr_nx = count_WERed - 5'd1;
        if (count_SNgreen == 5'd1) begin
          state_nx = S3;
          lamp_nx  = L_S3;
          sg_nx    = '0;
          sy_nx    = Y5;
        end
      end
      S3: begin
        sy_nx = count_SNyellow - 5'd1;
        wr_nx = count_WERed - 5'd1;
        if (count_SNyellow == 5'd1) begin
          state_nx = S0;
          lamp_nx  = L_S0;
          sy_nx    = '0;
          wr_nx    = '0;
          sr_nx    = R5;
          wg_nx    = G5;
        end
      end
      default: begin
        state_nx = S0;
        lamp_nx  = L_S0;
        wr_nx    = '0;
        sr_nx    = R5;
        wg_nx    = G5;
        sg_nx    = '0;
        wy_nx    = '0;
        sy_nx    = '0;
      end
    endcase
  end

  assign {WERed, WEyellow, WEgreen, SNRed, SNyellow, SNgreen} = cnt_out;

endmodule

// File: tb/tb_six_deng.sv
// Bench for six_deng: closed-form phase model feeds a scoreboard queue,
// plus a table of fixed spot vectors and a mid-phase reset sequence.
module tb_six_deng;
  localparam int G = 25;
  localparam int Y = 5;
  localparam int R = G + Y;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] cnt_out;
  logic [4:0] c_wr, c_sr, c_wg, c_sg, c_wy, c_sy;
  logic       WERed, SNRed, WEgreen, SNgreen, WEyellow, SNyellow;

  six_deng #(.GREEN_T(G), .YELLOW_T(Y)) dut (
    .clk(clk), .rst(rst), .cnt_out(cnt_out),
    .count_WERed(c_wr), .count_SNRed(c_sr),
    .count_WEgreen(c_wg), .count_SNgreen(c_sg),
    .count_WEyellow(c_wy), .count_SNyellow(c_sy),
    .WERed(WERed), .SNRed(SNRed), .WEgreen(WEgreen),
    .SNgreen(SNgreen), .WEyellow(WEyellow), .SNyellow(SNyellow)
  );

  always #5 clk = ~clk;

  // {cnt_out, WERed, SNRed, WEgreen, SNgreen, WEyellow, SNyellow counts}
  typedef logic [35:0] obs_t;
  typedef struct {
    int   edge_n;
    obs_t exp;
  } vec_t;

  vec_t     tbl[6];
  obs_t     sb_q[$];
  int       n_chk  = 0;
  int       n_fail = 0;
  int       t      = 0;
  int       edge_n = 0;

  function automatic obs_t pack(logic [5:0] l, int wr, int sr, int wg, int sg, int wy, int sy);
    return {l, 5'(wr), 5'(sr), 5'(wg), 5'(sg), 5'(wy), 5'(sy)};
  endfunction

  // Expected outputs as a function of ticks since reset, within one cycle.
  function automatic obs_t model(int tt);
    if (tt < G)          return pack(6'b001100, 0, R - tt, G - tt, 0, 0, 0);
    else if (tt < R)     return pack(6'b010100, 0, R - tt, 0, 0, R - tt, 0);
    else if (tt < R + G) return pack(6'b100001, 2*R - tt, 0, 0, R + G - tt, 0, 0);
    else                 return pack(6'b100010, 2*R - tt, 0, 0, 0, 0, 2*R - tt);
  endfunction

  function automatic obs_t observe();
    return {cnt_out, c_wr, c_sr, c_wg, c_sg, c_wy, c_sy};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%h want=%h", name, edge_n, act, exp);
    end
  endtask

  // One clock edge: model result queued as stimulus is applied, popped after.
  task automatic step();
    obs_t e;
    t = (!rst) ? 0 : (t + 1) % (2 * R);
    sb_q.push_back(model(t));
    @(posedge clk);
    #1;
    edge_n = (!rst) ? 0 : edge_n + 1;
    e = sb_q.pop_front();
    check("scoreboard", 64'(observe()), 64'(e));
    check("lamp_bits",
          64'({WERed, WEyellow, WEgreen, SNRed, SNyellow, SNgreen}), 64'(e[35:30]));
    check("one_lamp_per_dir",
          64'({$onehot(cnt_out[5:3]), $onehot(cnt_out[2:0])}), 64'(2'b11));
    check("lit_nonzero",
          64'({(cnt_out[5] && c_wr == 0), (cnt_out[4] && c_wy == 0), (cnt_out[3] && c_wg == 0),
               (cnt_out[2] && c_sr == 0), (cnt_out[1] && c_sy == 0), (cnt_out[0] && c_sg == 0)}),
          64'(0));
  endtask

  initial begin
    tbl[0] = '{1,  pack(6'b001100, 0, 29, 24, 0, 0, 0)};
    tbl[1] = '{24, pack(6'b001100, 0, 6, 1, 0, 0, 0)};
    tbl[2] = '{25, pack(6'b010100, 0, 5, 0, 0, 5, 0)};
    tbl[3] = '{30, pack(6'b100001, 30, 0, 0, 25, 0, 0)};
    tbl[4] = '{55, pack(6'b100010, 5, 0, 0, 0, 0, 5)};
    tbl[5] = '{60, pack(6'b001100, 0, 30, 25, 0, 0, 0)};

    // reset, held for two edges
    rst = 1'b0;
    step();
    step();
    check("reset_state", 64'(observe()), 64'(pack(6'b001100, 0, 30, 25, 0, 0, 0)));

    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      while (edge_n < tbl[i].edge_n) step();
      check($sformatf("table_edge%0d", tbl[i].edge_n), 64'(observe()), 64'(tbl[i].exp));
    end

    // second full cycle against the scoreboard alone
    repeat (65) step();

    // mid-phase reset at edge 40 of a fresh cycle
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (39) step();
    check("pre_midreset_s2", 64'(observe()), 64'(pack(6'b100001, 21, 0, 0, 16, 0, 0)));
    rst = 1'b0;
    step();
    check("midreset_state", 64'(observe()), 64'(pack(6'b001100, 0, 30, 25, 0, 0, 0)));
    rst = 1'b1;
    step();
    check("post_midreset_edge1", 64'(observe()), 64'(pack(6'b001100, 0, 29, 24, 0, 0, 0)));
    repeat (30) step();
    check("post_midreset_s2", 64'(observe()), 64'(pack(6'b100001, 29, 0, 0, 24, 0, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
